// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART receiver: frame constants, FSM
// state encoding and a constant-width helper.
package servant_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >> 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/servant_uart_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on data_o,
// and a push into a full FIFO is accepted only when a pop frees a slot.
module servant_uart_fifo
  import servant_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CNT_DEPTH);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign data_o    = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver for the servant console line: two-flop synchronizer,
// mid-bit sampling FSM and a small FWFT output FIFO on a valid/ready stream.
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int clks_per_bit = 278,
  parameter int fifo_depth   = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int CNT_W = clog2(clks_per_bit);
  localparam int IDX_W = clog2(UART_DATA_BITS);
  localparam int FCW   = clog2(fifo_depth) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(clks_per_bit - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(clks_per_bit / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_meta_q;
  logic                      rx_s_q;
  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overflow_q, overflow_d;
  logic                      tick_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic [FCW-1:0]            fifo_count_unused;

  assign tick_s      = (cnt_q == {CNT_W{1'b0}});
  assign o_valid     = !fifo_empty_s;
  assign pop_s       = o_valid && i_ready;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_s      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = CNT_HALF;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_FULL;
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + IDX_ONE;
          cnt_d          = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s_q) begin
          push_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      // A held-low line must return high before another start is accepted.
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign overflow_d = push_s && fifo_full_s && !pop_s;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      shift_q     <= {UART_DATA_BITS{1'b0}};
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Byte written on the stop-bit tick is the fully assembled shift_d.
  servant_uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk_i   (wb_clk),
    .rst_ni  (wb_rst_n),
    .push_i  (push_s),
    .data_i  (shift_d),
    .pop_i   (pop_s),
    .data_o  (o_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_unused)
  );

endmodule

// File: tb/tb_servant_uart_rx.sv
// Directed bench for servant_uart_rx at 16 clocks per bit and a 4-entry FIFO.
module tb_servant_uart_rx;

  localparam int CPB = 16;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       i_rx     = 1'b1;
  logic       i_ready  = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         cyc     = 0;
  int         n_pop   = 0;
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_ovf   = 0;
  int         ovf_cyc = -1;
  logic [7:0] pop_data [64];
  int         pop_cyc  [64];

  servant_uart_rx #(
    .clks_per_bit (CPB),
    .fifo_depth   (4)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc <= cyc + 1;

  always @(negedge wb_clk) begin
    if (o_valid) n_valid++;
    if (o_valid && i_ready && n_pop < 64) begin
      pop_data[n_pop] = o_data;
      pop_cyc[n_pop]  = cyc;
      n_pop++;
    end
    if (o_frame_err) n_ferr++;
    if (o_overflow) begin
      n_ovf++;
      ovf_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = 1'b1;
    tick(CPB);
  endtask

  initial begin
    int p0;
    int v0;
    int f0;
    int o0;
    int e0;
    int d0;

    tick(3);
    check("reset_valid", o_valid, 1'b0);
    check("reset_data", o_data, 8'h00);
    check("reset_ferr", o_frame_err, 1'b0);
    check("reset_ovf", o_overflow, 1'b0);
    wb_rst_n = 1'b1;
    tick(5);

    // Single byte with latency: 2 sync + 1 detect + 9.5 bits = 155 edges.
    i_ready = 1'b1;
    p0 = n_pop; v0 = n_valid; f0 = n_ferr; o0 = n_ovf; e0 = cyc;
    send_byte(8'h55);
    tick(10);
    check("single_pops", n_pop - p0, 1);
    check("single_data", pop_data[p0], 8'h55);
    check("single_latency", pop_cyc[p0] - e0, 155);
    check("single_valid_width", n_valid - v0, 1);
    check("single_ferr", n_ferr - f0, 0);
    check("single_ovf", n_ovf - o0, 0);

    p0 = n_pop;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h3C);
    tick(10);
    check("b2b_pops", n_pop - p0, 4);
    check("b2b_0", pop_data[p0], 8'h00);
    check("b2b_1", pop_data[p0+1], 8'hFF);
    check("b2b_2", pop_data[p0+2], 8'hA5);
    check("b2b_3", pop_data[p0+3], 8'h3C);

    p0 = n_pop; f0 = n_ferr;
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    tick(40);
    check("glitch_pops", n_pop - p0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // 0x81 with a low stop bit, line then held low for 40 cycles.
    p0 = n_pop; f0 = n_ferr;
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = (i == 0 || i == 7) ? 1'b1 : 1'b0;
      tick(CPB);
    end
    i_rx = 1'b0;
    tick(40);
    i_rx = 1'b1;
    tick(20);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_pops", n_pop - p0, 0);
    send_byte(8'h42);
    tick(10);
    check("after_ferr_pops", n_pop - p0, 1);
    check("after_ferr_data", pop_data[p0], 8'h42);
    check("after_ferr_ferr", n_ferr - f0, 1);

    i_ready = 1'b0;
    p0 = n_pop; o0 = n_ovf; f0 = n_ferr;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    e0 = cyc;
    send_byte(8'h05);
    tick(10);
    check("ovf_pulse", n_ovf - o0, 1);
    check("ovf_when", ovf_cyc - e0, 155);
    check("ovf_valid", o_valid, 1'b1);
    check("ovf_head", o_data, 8'h01);
    check("ovf_pops", n_pop - p0, 0);
    check("ovf_ferr", n_ferr - f0, 0);
    tick(5);
    check("ovf_head_stable", o_data, 8'h01);
    d0 = cyc;
    i_ready = 1'b1;
    tick(8);
    check("drain_pops", n_pop - p0, 4);
    check("drain_0", pop_data[p0], 8'h01);
    check("drain_1", pop_data[p0+1], 8'h02);
    check("drain_2", pop_data[p0+2], 8'h03);
    check("drain_3", pop_data[p0+3], 8'h04);
    check("drain_last_cyc", pop_cyc[p0+3] - d0, 3);
    check("drain_empty", o_valid, 1'b0);

    // Same fill, but a pop coincides with the fifth push.
    i_ready = 1'b0;
    p0 = n_pop; o0 = n_ovf;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    fork
      send_byte(8'h05);
      begin
        tick(154);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
      end
    join
    tick(10);
    check("pp_ovf", n_ovf - o0, 0);
    check("pp_pops", n_pop - p0, 1);
    check("pp_pop_data", pop_data[p0], 8'h01);
    check("pp_head", o_data, 8'h02);
    p0 = n_pop;
    i_ready = 1'b1;
    tick(8);
    check("pp_drain_pops", n_pop - p0, 4);
    check("pp_drain_0", pop_data[p0], 8'h02);
    check("pp_drain_3", pop_data[p0+3], 8'h05);

    // Reset pulse between the bit-2 and bit-3 samples of 0xF8.
    p0 = n_pop; v0 = n_valid;
    fork
      send_byte(8'hF8);
      begin
        tick(70);
        wb_rst_n = 1'b0;
        tick(1);
        wb_rst_n = 1'b1;
      end
    join
    tick(20);
    check("rst_mid_valid", n_valid - v0, 0);
    check("rst_mid_pops", n_pop - p0, 0);
    send_byte(8'h7E);
    tick(10);
    check("after_rst_pops", n_pop - p0, 1);
    check("after_rst_data", pop_data[p0], 8'h7E);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- Synthesizable UART receiver (8N1, LSB first, idle-high) that decodes the serial line driven by the servant SoC's q output.
- Turns the firmware's bit-banged console output back into bytes, for simulation benches and for on-board loopback/self-test.
- Decoded bytes are buffered in a small FIFO and presented on a valid/ready stream.

Parameters:
- clks_per_bit, 278, wb_clk cycles per UART bit (must be >= 4).
- fifo_depth, 4, output FIFO entries (power of two, >= 2).

Ports:
- wb_clk  input  1  system clock.
- wb_rst_n  input  1  synchronous reset, active-low.
- i_rx  input  1  serial line (servant q), asynchronous to wb_clk, idle high.
- o_data  output  8  head-of-FIFO byte.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overflow  output  1  one-cycle pulse: byte dropped because the FIFO was full.

Behaviour:
- Reset is synchronous: wb_rst_n low at a rising edge resets everything.
  - FSM goes to IDLE; FIFO empties.
  - o_valid=0, o_frame_err=0, o_overflow=0, o_data=0.
  - Synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame; no partial byte is ever pushed.
- Input sync: i_rx passes through 2 flops (rx_s). All decisions use rx_s, so a line edge reaches the FSM 2 cycles late.
- Bit timer: down-counter of width clog2(clks_per_bit). "Tick" means counter==0; the counter reloads on each tick.
- FSM states and transitions:
  - IDLE: if rx_s==0, load counter with clks_per_bit/2-1 and go to START.
  - START: on tick, sample rx_s. If 1, it is a glitch: go to IDLE with no flag. If 0, load clks_per_bit-1, clear bit index, go to DATA.
  - DATA: on each tick, shift rx_s into bit[index] (LSB first) and increment index. After the 8th sample, go to STOP.
  - STOP: on tick, sample rx_s.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse o_frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Prevents re-triggering on a held-low line.
- Sampling is at mid-bit. Back-to-back frames with a 1-bit stop are supported: IDLE is re-entered half a bit before the next start edge.
- FIFO (first-word fall-through):
  - A push writes on the STOP tick edge; o_valid is high the next cycle.
  - A pop occurs when o_valid && i_ready; the next entry appears on o_data the following cycle.
  - A push is accepted if count<fifo_depth or a pop happens in the same cycle.
  - Otherwise the new byte is dropped, o_overflow pulses for 1 cycle, and the FIFO contents are unchanged.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo fifo_depth.
  - o_data is stable while o_valid && !i_ready.
- Pulses o_frame_err and o_overflow are registered, exactly 1 cycle wide, and never both asserted for the same frame.

Decomposition:
- Package servant_uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BREAK).
  - UART_DATA_BITS=8.
  - Helper function clog2.
- One sub-module, servant_uart_fifo: parameterized width/depth FWFT FIFO providing push, pop, full, empty and a count output.
- Synchronizer, timer and FSM stay in servant_uart_rx.

Test Plan (clks_per_bit=16, fifo_depth=4):
- Single byte: drive 0x55 8N1, i_ready=1 → o_valid pulses for 1 cycle with o_data=0x55. o_valid rises 1 cycle after the mid-stop sample, 2 sync cycles plus 9.5 bits after the start edge. No error pulses.
- Back-to-back frames: 0x00, 0xFF, 0xA5, 0x3C with zero idle between them → all four are received in order.
- Glitch: a low pulse of 4 cycles on an idle line → nothing pushed, no o_frame_err, FSM back in IDLE.
- Framing error: byte 0x81 with the stop bit low, line held low 40 cycles, then high → one o_frame_err pulse, no push. A following 0x42 frame is received correctly.
- Overflow:
  - i_ready=0; send 0x01..0x05 → FIFO holds 0x01..0x04 and o_overflow pulses once, on 0x05's stop tick.
  - Raise i_ready → 0x01..0x04 drain in order over 4 cycles.
  - Repeat with i_ready pulsed exactly on the 5th push cycle → no overflow; 0x05 is retained.
- Reset mid-frame: assert wb_rst_n=0 for 1 cycle during DATA bit 3 → o_valid stays 0. The next clean 0x7E is received correctly.
